// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe.sv
// ============================================================================
// Module      : gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe
// Description : WIDTH x DEPTH scan register bank / retiming pipeline.
//               Functional mode: enable-gated parallel pipeline, D -> Q after
//               DEPTH enabled edges. Scan mode: the whole bank is one serial
//               chain SI -> stage[0][0] .. stage[DEPTH-1][WIDTH-1] -> SO.
//               Optional macro GF180MCU_SDFFR_PIPE_PARITY_EN adds a parity
//               bit per stage (scanned after that stage's data bits) and a
//               sticky QPERR output.
// Ports       : CLK   - clock, rising edge
//               RST   - asynchronous reset, active high
//               E     - functional advance enable
//               SE    - scan enable (overrides E)
//               SI    - scan serial input
//               D     - parallel data in  [WIDTH-1:0]
//               Q     - last-stage data   [WIDTH-1:0]
//               QPERR - sticky parity error (parity build only)
//               SO    - scan serial output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
    output logic             QPERR,
`endif
    output logic             SO
);

`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    // Each stage segment holds its data bits, then (optionally) its parity bit
    // at the top, so the flattened segment array is exactly the scan chain.
    localparam int c_SEG_W = WIDTH + c_PAR;
    localparam int c_N     = c_SEG_W * DEPTH;

    logic [DEPTH-1:0][c_SEG_W-1:0] seg_q;
    logic [DEPTH-1:0][c_SEG_W-1:0] seg_d;
    logic [c_N-1:0]                w_flat;
    logic [c_N-1:0]                w_shift;

    assign w_flat = seg_q;

    // Chain shift: every bit takes its lower-index neighbour, SI enters bit 0.
    generate
        if (c_N == 1) begin : g_chain_one
            assign w_shift = SI;
        end else begin : g_chain_many
            assign w_shift = {w_flat[c_N-2:0], SI};
        end
    endgenerate

    always_comb begin
        seg_d = seg_q;
        if (SE) begin
            seg_d = w_shift;
        end else if (E) begin
            seg_d[0][WIDTH-1:0] = D;
`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
            seg_d[0][WIDTH] = ^D;
`endif
            for (int k = 1; k < DEPTH; k++) begin
                seg_d[k] = seg_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_q <= '0;
        end else begin
            seg_q <= seg_d;
        end
    end

`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
    logic qperr_q;
    logic qperr_d;

    // The check uses the last stage as it stands before the advancing edge,
    // so a scan-injected mismatch is caught on the first functional advance.
    always_comb begin
        qperr_d = qperr_q;
        if (!SE && E &&
            ((^seg_q[DEPTH-1][WIDTH-1:0]) != seg_q[DEPTH-1][WIDTH])) begin
            qperr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            qperr_q <= 1'b0;
        end else begin
            qperr_q <= qperr_d;
        end
    end

    assign QPERR = qperr_q;
`endif

    assign Q  = seg_q[DEPTH-1][WIDTH-1:0];
    assign SO = w_flat[c_N-1];

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe.sv
// ============================================================================
// Module      : tb_gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe
// Description : Directed self-checking bench, WIDTH=8 DEPTH=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       E   = 1'b0;
    logic       SE  = 1'b0;
    logic       SI  = 1'b0;
    logic [7:0] D   = 8'h00;
    logic [7:0] Q;
    logic       SO;
`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
    logic       QPERR;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__sdffr_pipe #(.WIDTH(8), .DEPTH(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .E     (E),
        .SE    (SE),
        .SI    (SI),
        .D     (D),
        .Q     (Q),
`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
        .QPERR (QPERR),
`endif
        .SO    (SO)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] pat;

    initial begin
        pat = 16'hF00D;

        // ---- reset state ----
        #2;
        check("rst_q", {8'h0, Q}, 16'h0000);
        check("rst_so", {15'h0, SO}, 16'h0000);
        tick();
        RST = 1'b0;

        // ---- mid-operation reset ----
        E = 1'b1;
        for (int i = 0; i < 5; i++) begin
            D = 8'($urandom_range(1, 255));
            tick();
        end
        RST = 1'b1;
        #1;
        check("midrst_q", {8'h0, Q}, 16'h0000);
        check("midrst_so", {15'h0, SO}, 16'h0000);
        tick();
        RST = 1'b0;
        E   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            D = 8'hFF;
            tick();
            check("postrst_q", {8'h0, Q}, 16'h0000);
            check("postrst_so", {15'h0, SO}, 16'h0000);
        end

        // ---- latency ----
        E = 1'b1;
        D = 8'hA5; tick(); check("lat_e1", {8'h0, Q}, 16'h0000);
        D = 8'h3C; tick(); check("lat_e2", {8'h0, Q}, 16'h00A5);
        D = 8'h00; tick(); check("lat_e3", {8'h0, Q}, 16'h003C);

        // ---- hold ----
        D = 8'hA5; tick();
        D = 8'h11; tick(); check("hold_load", {8'h0, Q}, 16'h00A5);
        E = 1'b0;
        for (int i = 0; i < 4; i++) begin
            D = (i % 2 == 0) ? 8'h5A : 8'hC3;
            tick();
            check("hold_q", {8'h0, Q}, 16'h00A5);
        end
        E = 1'b1;
        D = 8'h22; tick(); check("resume1", {8'h0, Q}, 16'h0011);
        D = 8'h33; tick(); check("resume2", {8'h0, Q}, 16'h0022);

        // ---- scan load of 0xF00D, LSB first, E=1 and D busy ----
        SE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            SI = pat[i];
            D  = 8'($urandom);
            tick();
        end
        // First-in bit sits at the chain end: Q[j] = pat[7-j] -> 0xB0.
        check("scan_q", {8'h0, Q}, 16'h00B0);
        // ---- scan unload: SO shows pattern bits in shift-in order ----
        SI = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("scan_so", {15'h0, SO}, {15'h0, pat[i]});
            tick();
        end
        check("scan_flush", {8'h0, Q}, 16'h0000);

        // ---- priority: SE wins over E ----
        SE = 1'b1; E = 1'b1; D = 8'hFF; SI = 1'b0;
        tick();
        check("prio_q", {8'h0, Q}, 16'h0000);
        check("prio_so", {15'h0, SO}, 16'h0000);
        SE = 1'b0; E = 1'b1; D = 8'h00;
        tick();
        check("prio_clean", {8'h0, Q}, 16'h0000);

`ifdef GF180MCU_SDFFR_PIPE_PARITY_EN
        // ---- parity: inject stage1 = 0x01 with parity 0 ----
        check("par_init", {15'h0, QPERR}, 16'h0000);
        SE = 1'b1;
        for (int i = 0; i < 18; i++) begin
            SI = (i == 8);   // lands on chain bit 9 = stage[1][0]
            tick();
        end
        check("par_load_q", {8'h0, Q}, 16'h0001);
        check("par_before", {15'h0, QPERR}, 16'h0000);
        SE = 1'b0; E = 1'b1; D = 8'h00; SI = 1'b0;
        tick();
        check("par_set", {15'h0, QPERR}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            D = 8'h03;
            tick();
            check("par_sticky", {15'h0, QPERR}, 16'h0001);
        end
        RST = 1'b1;
        #1;
        check("par_clear", {15'h0, QPERR}, 16'h0000);
        tick();
        RST = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
